// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: sequencer between the UART command path and cmd_proc.
//
// Holds a small buffer of knight-move indices (0..7). On start_tour each
// buffered move is expanded into two cmd_proc commands: a vertical leg
// (opcode 4) followed by a horizontal leg (opcode 5, move with fanfare).
// Each command is offered with cmd_rdy, retired by clr_cmd_rdy, and the
// sequencer then waits for send_resp before offering the next one.
// When no tour is running the UART command path goes straight through.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   mv_wr/mv_idx/
//   mv_data           move-buffer write port (honoured only while idle)
//   num_moves         tour length, sampled with start_tour (1..MAX_MOVES)
//   start_tour        single-cycle pulse that begins a tour
//   cmd_UART,
//   cmd_rdy_UART      command + valid from the UART wrapper
//   clr_cmd_rdy_UART  accept strobe back to the UART wrapper (idle only)
//   cmd, cmd_rdy      command + valid to cmd_proc
//   clr_cmd_rdy       cmd_proc accepted the command
//   send_resp         cmd_proc finished the command
//   resp              response byte: 8'h5A on the final ack, else 8'hA5
//   tour_busy         high while a tour is being sequenced
module tour_cmd_seq #(
  parameter int MAX_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mv_wr,
  input  logic [4:0]  mv_idx,
  input  logic [2:0]  mv_data,
  input  logic [4:0]  num_moves,
  input  logic        start_tour,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_busy
);

  typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

  localparam logic [7:0] HD_N     = 8'h00;
  localparam logic [7:0] HD_W     = 8'h3F;
  localparam logic [7:0] HD_S     = 8'h7F;
  localparam logic [7:0] HD_E     = 8'hBF;
  localparam logic [3:0] OP_V     = 4'h4;
  localparam logic [3:0] OP_H     = 4'h5;
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_FIN = 8'h5A;

  // Move buffer, one 3-bit index per entry.
  logic [MAX_MOVES-1:0][2:0] mv_buf;

  state_t      state, state_nxt;
  logic [4:0]  ptr, ptr_nxt, ptr_inc;
  logic [4:0]  num_q, num_nxt;
  logic [15:0] cmd_q, cmd_nxt;
  logic        num_ok, last_move;

  // Vertical leg of a knight move: heading from sign of dy, squares |dy|.
  function automatic logic [15:0] leg_v(input logic [2:0] m);
    case (m)
      3'd0, 3'd1: leg_v = {OP_V, HD_N, 4'd2};
      3'd2, 3'd7: leg_v = {OP_V, HD_N, 4'd1};
      3'd3, 3'd6: leg_v = {OP_V, HD_S, 4'd1};
      default:    leg_v = {OP_V, HD_S, 4'd2};   // 4, 5
    endcase
  endfunction

  // Horizontal leg: heading from sign of dx, squares |dx|.
  function automatic logic [15:0] leg_h(input logic [2:0] m);
    case (m)
      3'd0, 3'd5: leg_h = {OP_H, HD_E, 4'd1};
      3'd1, 3'd4: leg_h = {OP_H, HD_W, 4'd1};
      3'd2, 3'd3: leg_h = {OP_H, HD_W, 4'd2};
      default:    leg_h = {OP_H, HD_E, 4'd2};   // 6, 7
    endcase
  endfunction

  assign num_ok    = (num_moves != 5'd0) && (int'(num_moves) <= MAX_MOVES);
  assign ptr_inc   = ptr + 5'd1;
  assign last_move = (ptr == num_q - 5'd1);

  // Buffer writes are accepted only while idle so a running tour always
  // sees the list it was started with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mv_buf <= '0;
    end else if (mv_wr && (state == IDLE) && (int'(mv_idx) < MAX_MOVES)) begin
      mv_buf[mv_idx] <= mv_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      num_q <= '0;
      cmd_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      num_q <= num_nxt;
      cmd_q <= cmd_nxt;
    end
  end

  // cmd_q is loaded on the edge that enters VERT/HORZ and is left alone
  // until that leg's send_resp, so cmd_proc sees a stable command
  // through the whole handshake.
  always_comb begin
    state_nxt        = state;
    ptr_nxt          = ptr;
    num_nxt          = num_q;
    cmd_nxt          = cmd_q;
    cmd              = cmd_q;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    tour_busy        = 1'b1;
    resp             = RESP_ACK;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        tour_busy        = 1'b0;
        if (start_tour && num_ok) begin
          num_nxt   = num_moves;
          ptr_nxt   = '0;
          cmd_nxt   = leg_v(mv_buf[0]);
          state_nxt = VERT;
        end
      end
      // In the offer states send_resp is ignored; clr_cmd_rdy wins even
      // if both arrive together.
      VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HOLD_V;
      end
      HOLD_V: begin
        if (send_resp) begin
          cmd_nxt   = leg_h(mv_buf[ptr]);
          state_nxt = HORZ;
        end
      end
      HORZ: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HOLD_H;
      end
      HOLD_H: begin
        if (send_resp) begin
          if (last_move) begin
            resp      = RESP_FIN;
            state_nxt = IDLE;
          end else begin
            ptr_nxt   = ptr_inc;
            cmd_nxt   = leg_v(mv_buf[ptr_inc]);
            state_nxt = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq. Expected commands are derived from a
// (dy,dx) move table and pushed to a scoreboard queue when a tour is
// started; a cmd_proc responder pops and compares as commands appear.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv_wr;
  logic [4:0]  mv_idx;
  logic [2:0]  mv_data;
  logic [4:0]  num_moves;
  logic        start_tour;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_busy;

  always #5 clk = ~clk;

  tour_cmd_seq #(.MAX_MOVES(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .mv_wr(mv_wr), .mv_idx(mv_idx), .mv_data(mv_data),
    .num_moves(num_moves), .start_tour(start_tour),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .tour_busy(tour_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [2:0]  mdl_buf[24];
  int dy_t[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int dx_t[8] = '{1, -1, -2, -2, -1, 1, 2, 2};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mdl_v(input logic [2:0] m);
    int d = dy_t[m];
    return {4'h4, (d > 0) ? 8'h00 : 8'h7F, 4'((d < 0) ? -d : d)};
  endfunction

  function automatic logic [15:0] mdl_h(input logic [2:0] m);
    int d = dx_t[m];
    return {4'h5, (d > 0) ? 8'hBF : 8'h3F, 4'((d < 0) ? -d : d)};
  endfunction

  task automatic wr(input int idx, input logic [2:0] d);
    mv_idx = 5'(idx); mv_data = d; mv_wr = 1'b1;
    step();
    mv_wr = 1'b0;
    if (idx < 24) mdl_buf[idx] = d;
  endtask

  task automatic start(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(mdl_v(mdl_buf[i]));
      sb.push_back(mdl_h(mdl_buf[i]));
    end
    num_moves = 5'(n); start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    chk("start_latency_rdy", 16'(cmd_rdy), 16'd1);
    chk("start_busy", 16'(tour_busy), 16'd1);
  endtask

  // Act as cmd_proc for one leg.
  // mode 0: normal; 1: perturb in VERT and HOLD; 2: clr+send together;
  // 3: stop after acceptance (leave DUT in the HOLD state).
  task automatic serve(input bit last, input int mode);
    logic [15:0] e;
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin step(); n++; end
    chk("cmd_rdy_wait", 16'(cmd_rdy), 16'd1);
    chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
    e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
    chk("cmd", cmd, e);
    if (mode == 1) begin
      send_resp = 1'b1; start_tour = 1'b1; num_moves = 5'd1;
      mv_idx = 5'd0; mv_data = 3'd5; mv_wr = 1'b1; cmd_rdy_UART = 1'b1;
      #1;
      chk("uart_clr_offer", 16'(clr_cmd_rdy_UART), 16'd0);
      chk("resp_offer", 16'(resp), 16'hA5);
      step();
      send_resp = 1'b0; start_tour = 1'b0; mv_wr = 1'b0; cmd_rdy_UART = 1'b0;
      chk("stay_offer_rdy", 16'(cmd_rdy), 16'd1);
      chk("stay_offer_cmd", cmd, e);
    end
    clr_cmd_rdy = 1'b1;
    if (mode == 2) send_resp = 1'b1;
    step();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    chk("rdy_drop", 16'(cmd_rdy), 16'd0);
    chk("cmd_hold", cmd, e);
    if (mode == 1) begin
      clr_cmd_rdy = 1'b1; cmd_rdy_UART = 1'b1;
      #1;
      chk("uart_clr_hold", 16'(clr_cmd_rdy_UART), 16'd0);
      step();
      clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
      chk("hold_ignores_clr", 16'(cmd_rdy), 16'd0);
    end
    if (mode == 2) begin
      step();
      chk("both_only_clr", 16'(cmd_rdy), 16'd0);
    end
    if (mode == 3) return;
    step();
    send_resp = 1'b1;
    #1;
    chk("resp", 16'(resp), 16'(last ? 8'h5A : 8'hA5));
    step();
    send_resp = 1'b0;
    chk("next_rdy", 16'(cmd_rdy), 16'(!last));
    chk("busy_after_resp", 16'(tour_busy), 16'(!last));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mv_wr = 1'b0; mv_idx = '0; mv_data = '0; num_moves = '0;
    start_tour = 1'b0; cmd_UART = '0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < 24; i++) mdl_buf[i] = 3'd0;
    step(); step();
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
    chk("rst_busy", 16'(tour_busy), 16'd0);
    chk("rst_resp", 16'(resp), 16'hA5);
    chk("rst_uart_clr", 16'(clr_cmd_rdy_UART), 16'd0);
    rst_n = 1'b1;
    step();

    // Idle passthrough
    cmd_UART = 16'h4BF1; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("pass_cmd", cmd, 16'h4BF1);
    chk("pass_rdy", 16'(cmd_rdy), 16'd1);
    chk("pass_clr", 16'(clr_cmd_rdy_UART), 16'd1);
    chk("pass_busy", 16'(tour_busy), 16'd0);
    chk("pass_resp", 16'(resp), 16'hA5);
    step();
    cmd_UART = '0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;

    // Illegal starts
    num_moves = 5'd0; start_tour = 1'b1; step(); start_tour = 1'b0;
    chk("ill0_busy", 16'(tour_busy), 16'd0);
    chk("ill0_rdy", 16'(cmd_rdy), 16'd0);
    num_moves = 5'd25; start_tour = 1'b1; step(); start_tour = 1'b0;
    chk("ill25_busy", 16'(tour_busy), 16'd0);
    step();
    chk("ill25_busy_later", 16'(tour_busy), 16'd0);

    // Single move: expect 4001 then 5BF2
    wr(0, 3'd7);
    start(1);
    chk("single_first_cmd", cmd, 16'h4001);
    serve(1'b0, 0);
    serve(1'b1, 0);

    // Three-move tour {0,4,2} with protocol perturbations on the first legs
    wr(0, 3'd0); wr(1, 3'd4); wr(2, 3'd2);
    wr(24, 3'd3);
    start(3);
    serve(1'b0, 1);
    serve(1'b0, 2);
    serve(1'b0, 0);
    serve(1'b0, 0);
    serve(1'b0, 0);
    serve(1'b1, 0);
    chk("tour3_sb_drained", 16'(sb.size()), 16'd0);

    // mv_wr during the tour must not have landed: buf[0] still 0
    start(1);
    chk("post_wr_cmd", cmd, 16'h4002);
    serve(1'b0, 0);
    serve(1'b1, 0);

    // Reset in HOLD_H of move 2
    wr(0, 3'd1); wr(1, 3'd3);
    start(2);
    serve(1'b0, 0);
    serve(1'b0, 0);
    serve(1'b0, 0);
    serve(1'b0, 3);
    rst_n = 1'b0;
    step();
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_rdy", 16'(cmd_rdy), 16'd0);
    chk("midrst_busy", 16'(tour_busy), 16'd0);
    chk("midrst_resp", 16'(resp), 16'hA5);
    chk("midrst_uart_clr", 16'(clr_cmd_rdy_UART), 16'd0);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 24; i++) mdl_buf[i] = 3'd0;
    step();
    start(1);
    chk("after_rst_cmd", cmd, 16'h4002);
    serve(1'b0, 0);
    serve(1'b1, 0);
    chk("final_sb_drained", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sequencer between the UART command path and cmd_proc.
- Buffers a list of knight-move indices and, on start_tour, expands each move into two cmd_proc move commands: a vertical leg, then a horizontal leg.
- Issues each command with the cmd_rdy/clr_cmd_rdy handshake and waits for cmd_proc's send_resp before issuing the next.
- When no tour is running it passes the UART command path straight through to cmd_proc.

Parameters:
MAX_MOVES, 24, depth of move buffer; legal num_moves range is 1..MAX_MOVES

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
mv_wr  input  1  write strobe for move buffer
mv_idx  input  5  buffer address for mv_wr
mv_data  input  3  knight-move index 0..7
num_moves  input  5  tour length, sampled on start_tour
start_tour  input  1  single-cycle pulse, begins tour
cmd_UART  input  16  command from UART wrapper
cmd_rdy_UART  input  1  UART command valid
clr_cmd_rdy_UART  output  1  clears UART cmd_rdy (idle passthrough)
cmd  output  16  command to cmd_proc
cmd_rdy  output  1  command valid to cmd_proc
clr_cmd_rdy  input  1  cmd_proc accepted command
send_resp  input  1  cmd_proc finished command
resp  output  8  response byte to UART
tour_busy  output  1  high while sequencing

Behaviour:
- Command format: [15:12] opcode, [11:4] heading byte, [3:0] squares.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Leg 1 (vertical) uses opcode 4. Leg 2 (horizontal) uses opcode 5 (move with fanfare).
- Move table, given as (dy,dx):
  - 0:(+2,+1)
  - 1:(+2,-1)
  - 2:(+1,-2)
  - 3:(-1,-2)
  - 4:(-2,-1)
  - 5:(-2,+1)
  - 6:(-1,+2)
  - 7:(+1,+2)
- Leg 1 = {4'h4, dy>0?N:S, |dy|}. Leg 2 = {4'h5, dx>0?E:W, |dx|}.
- Buffer: MAX_MOVES x 3 registers. mv_wr writes mv_data at mv_idx only in IDLE; it is ignored while tour_busy. Writes with mv_idx >= MAX_MOVES are ignored. Reset clears all entries to 0.
- States:
  - IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, tour_busy=0.
    - start_tour with 1<=num_moves<=MAX_MOVES: latch num_moves, ptr<=0, go to VERT next cycle.
    - Any other num_moves: start_tour is ignored.
  - VERT: cmd=leg1(buf[ptr]), cmd_rdy=1. On clr_cmd_rdy go to HOLD_V; cmd_rdy is low the next cycle.
  - HOLD_V: cmd_rdy=0, cmd holds leg1. On send_resp go to HORZ.
  - HORZ: cmd=leg2(buf[ptr]), cmd_rdy=1. On clr_cmd_rdy go to HOLD_H.
  - HOLD_H: cmd_rdy=0. On send_resp:
    - if ptr==num_moves-1, go to IDLE;
    - else ptr<=ptr+1 and go to VERT.
- In any state other than IDLE: tour_busy=1, clr_cmd_rdy_UART=0, and cmd_UART/cmd_rdy_UART are ignored.
- cmd is registered. The internal cmd is stable from entry to VERT/HORZ until that leg's send_resp.
- resp is combinational:
  - 8'h5A when state==HOLD_H, ptr==num_moves-1 and send_resp=1 (final ack);
  - 8'hA5 otherwise.
- Boundary behaviour:
  - start_tour while busy is ignored.
  - send_resp in VERT/HORZ (before clr_cmd_rdy) is ignored.
  - clr_cmd_rdy in HOLD states is ignored.
  - clr_cmd_rdy and send_resp arriving in the same cycle in VERT/HORZ: only clr_cmd_rdy is acted on.
  - Reset mid-tour: IDLE, ptr=0, cmd=0, cmd_rdy=0, tour_busy=0, buffer cleared. This is the reset value of every output; resp reads 8'hA5 and clr_cmd_rdy_UART reads 0 in IDLE with no input.
- Latency:
  - start_tour to first cmd_rdy: 1 cycle.
  - send_resp to next leg's cmd_rdy: 1 cycle.

Test Plan:
- Idle passthrough: cmd_UART=16'h4BF1, cmd_rdy_UART=1, clr_cmd_rdy=1 -> cmd=16'h4BF1, cmd_rdy=1, clr_cmd_rdy_UART=1, tour_busy=0, resp=8'hA5.
- Single move:
  - Stimulus: buf[0]=7, num_moves=1, start_tour.
  - Expected: cmd_rdy with 16'h4001 one cycle later. After clr_cmd_rdy and send_resp, 16'h5BF2 is issued. Its send_resp gives resp=8'h5A that cycle and tour_busy=0 the next.
- Three-move tour with buffer {0,4,2}:
  - Expected command order: 4002, 5BF1, 47F2, 53F1, 4001, 53F2.
  - resp=A5 on the first five send_resp, 5A on the sixth.
- Illegal starts: num_moves=0 and num_moves=25 -> stays IDLE, tour_busy=0. start_tour during a tour -> ptr is not reset and the command sequence is unchanged.
- Protocol robustness:
  - send_resp asserted in VERT before clr_cmd_rdy -> stays VERT.
  - mv_wr during the tour -> buffer unchanged; a later tour shows the original data.
  - cmd_rdy_UART during the tour -> no clr_cmd_rdy_UART.
- Reset mid-tour: rst_n low in HOLD_H of move 2 -> next cycle all outputs at reset values; a new tour with buffer all zeros issues 16'h4002.
